dm_mem: RTL and testbench
=========================

# dm_mem

Data-memory stage of the five-stage MIPS pipeline. Consumes the EX/MEM pipeline register outputs and performs stores into a word-organised data memory. Also returns sign- or zero-extended load data to the MEM/WB register in the same cycle. Supports lw/lh/lhu/lb/lbu and sw/sh/sb; all other opcodes are no-ops.

## Interface
Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words; byte address range 0x0000 .. 4*DEPTH_WORDS-1
- ADDR_W, 12, word-index width; must satisfy 2^ADDR_W >= DEPTH_WORDS

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high; clears the whole memory array
- INS_M  in  32  instruction in MEM stage; opcode is INS_M[31:26]
- PC_M  in  32  PC of that instruction; used only for the write log
- ALU_M  in  32  effective byte address
- WD_M  in  32  store data, already forwarded
- DMout_M  out  32  extended load data; 0 for non-load instructions
- DMwe_M  out  1  high when a store actually commits this cycle

## Operation
- Decode, by opcode:
  - sw 101011, sh 101001, sb 101000
  - lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100
- Word index: ALU_M[ADDR_W+1:2]. In range only if ALU_M[31:2] < DEPTH_WORDS.
- Store byte enables (BE[3:0]):
  - sw → 1111; ALU_M[1:0] ignored
  - sh → 0011 << (2*ALU_M[1]); ALU_M[0] ignored
  - sb → 0001 << ALU_M[1:0]
- Store data lanes:
  - sh replicates WD_M[15:0] into both halves
  - sb replicates WD_M[7:0] into all four bytes
  - only enabled bytes are written; other bytes keep their old value
- Stores whose address is out of range are dropped; DMwe_M is 0 for them.
- Loads: the addressed word is read combinationally (out-of-range reads give 0), then:
  - lw: the full word
  - lh/lhu: the half selected by ALU_M[1], sign- or zero-extended to 32
  - lb/lbu: the byte selected by ALU_M[1:0], sign- or zero-extended to 32
- Non-load instructions drive DMout_M = 0.

## Timing
- Writes commit at the rising edge of clk when reset=0 and a store is decoded in range. No stall and no handshake; the block is always ready.
- Reads are combinational on the current array contents. A load in cycle N+1 to an address stored in cycle N sees the new data.
- A load and store in the same instruction cannot occur. DMout_M in a store cycle is 0.
- Reset:
  - all DEPTH_WORDS words become 0 at the edge where reset=1
  - a store presented in that same cycle is dropped and not logged
  - after reset, every load returns 0 until it is written
- DMwe_M is combinational and equals 0 whenever reset=1.
- No internal state other than the array, so there are no FSM states. Behaviour mid-sequence after reset is simply the cleared-array case.

## Configuration
- DM_WRITE_LOG_EN defined:
  - every committed store prints, at the commit edge: "%d@%h: *%h <= %h" with $time, PC_M, the word-aligned byte address {ALU_M[31:2],2'b00}, and the full 32-bit word after merging
  - dropped stores and stores during reset print nothing
- DM_WRITE_LOG_EN undefined: no $display is compiled; functional behaviour is identical.

## Structure
- Shared package mips_pkg holds the opcode localparams (OP_SW, OP_SH, OP_SB, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU). The EX and WB stages decode from the same constants.
- One sub-module, dm_lane: combinational logic that takes the opcode and ALU_M[1:0] and produces the byte enables, replicated store data, and load extraction/extension.
- dm_mem owns the array, the range check, the commit logic and the log.

## Test plan
- Reset, then lw at 0x0000 and 0x2FFC → DMout_M=0x00000000 for both.
- sw 0x12345678 at 0x0010, next cycle lw 0x0010 → 0x12345678; log shows "*00000010 <= 12345678".
- With 0x12345678 at 0x0010:
  - sb 0xAB at 0x0011 → word 0x1234AB78
  - lb 0x0011 → 0xFFFFFFAB
  - lbu 0x0011 → 0x000000AB
- sh 0x8001 at 0x0012 onto 0x1234AB78 → word 0x8001AB78; lh 0x0012 → 0xFFFF8001; lhu 0x0012 → 0x00008001.
- Out-of-range sw at 0x3000 → DMwe_M=0, no log line, and lw 0x3000 → 0.
- sw 0xDEADBEEF at 0x0020 with reset=1 in the same cycle → dropped; lw 0x0020 → 0. Then sw without reset followed by a reset pulse → lw 0x0020 → 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants shared by the EX, MEM and WB pipeline stages.
package mips_pkg;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
endpackage

// File: rtl/dm_lane.sv
// dm_lane: byte enables, store lane replication and load extraction/extension for the MEM stage.
module dm_lane
  import mips_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  a,
  input  logic [31:0] wd,
  input  logic [31:0] rd,
  output logic        store,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [15:0] h;
  logic [7:0]  b;
  logic [31:0] sh_rd;
  always_comb begin
    store = op == OP_SW || op == OP_SH || op == OP_SB;
    be    = op == OP_SW ? 4'hf :
            op == OP_SH ? (a[1] ? 4'hc : 4'h3) :
            op == OP_SB ? 4'b0001 << a : 4'h0;
    wdata = op == OP_SW ? wd : op == OP_SH ? {2{wd[15:0]}} : {4{wd[7:0]}};
    sh_rd = rd >> {a, 3'b000};
    h     = a[1] ? rd[31:16] : rd[15:0];
    b     = sh_rd[7:0];
    rdata = op == OP_LW  ? rd :
            op == OP_LH  ? {{16{h[15]}}, h} :
            op == OP_LHU ? {16'h0, h} :
            op == OP_LB  ? {{24{b[7]}}, b} :
            op == OP_LBU ? {24'h0, b} : 32'h0;
  end
endmodule

// File: rtl/dm_mem.sv
// dm_mem: MIPS data-memory stage with byte/half/word stores and extended loads; DM_WRITE_LOG_EN enables the commit log.
module dm_mem
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int ADDR_W      = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] INS_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] ALU_M,
  input  logic [31:0] WD_M,
  output logic [31:0] DMout_M,
  output logic        DMwe_M
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] idx;
  logic in_range, store;
  logic [3:0] be;
  logic [31:0] rd, wdata, merged;
  dm_lane u_lane (
    .op(INS_M[31:26]), .a(ALU_M[1:0]), .wd(WD_M), .rd(rd),
    .store(store), .be(be), .wdata(wdata), .rdata(DMout_M)
  );
  always_comb begin
    idx      = ALU_M[ADDR_W+1:2];
    in_range = ALU_M[31:2] < 30'(DEPTH_WORDS);
    rd       = in_range ? mem[idx] : 32'h0;
    DMwe_M   = !reset && store && in_range;
    merged   = rd;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (DMwe_M) begin
      mem[idx] <= merged;
`ifdef DM_WRITE_LOG_EN
      $display("%d@%h: *%h <= %h", $time, PC_M, {ALU_M[31:2], 2'b00}, merged);
`else
`endif
    end
  end
endmodule

// File: tb/tb_dm_mem.sv
// tb_dm_mem: directed scoreboard bench for dm_mem loads, stores, range checks and reset clearing.
module tb_dm_mem;
  import mips_pkg::*;
  logic clk = 0, reset = 0;
  logic [31:0] INS_M = 0, PC_M = 0, ALU_M = 0, WD_M = 0;
  logic [31:0] DMout_M;
  logic DMwe_M;
  int checks = 0, failures = 0;
  typedef struct { string tag; logic [31:0] out; logic we; } exp_t;
  exp_t sb[$];
  localparam logic [5:0] NOP = 6'b000000;
  dm_mem dut (
    .clk(clk), .reset(reset), .INS_M(INS_M), .PC_M(PC_M),
    .ALU_M(ALU_M), .WD_M(WD_M), .DMout_M(DMout_M), .DMwe_M(DMwe_M)
  );
  always #5 clk = ~clk;
  task automatic step(input string tag, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] wd, input logic r, input logic [31:0] eo, input logic ew);
    exp_t e;
    @(negedge clk);
    INS_M = {op, 26'h0};
    PC_M  = PC_M + 32'd4;
    ALU_M = a;
    WD_M  = wd;
    reset = r;
    sb.push_back('{tag, eo, ew});
    #1;
    e = sb.pop_front();
    checks++;
    assert (DMout_M === e.out) else begin
      failures++;
      $error("FAIL %s DMout_M got %h expected %h", e.tag, DMout_M, e.out);
    end
    checks++;
    assert (DMwe_M === e.we) else begin
      failures++;
      $error("FAIL %s DMwe_M got %b expected %b", e.tag, DMwe_M, e.we);
    end
  endtask
  initial begin
    step("reset",        NOP,    32'h0000, 32'h0,        1, 32'h0,        0);
    step("lw0_cleared",  OP_LW,  32'h0000, 32'h0,        0, 32'h0,        0);
    step("lw_top_clr",   OP_LW,  32'h2FFC, 32'h0,        0, 32'h0,        0);
    step("sw10",         OP_SW,  32'h0010, 32'h12345678, 0, 32'h0,        1);
    step("lw10",         OP_LW,  32'h0010, 32'h0,        0, 32'h12345678, 0);
    step("sb11",         OP_SB,  32'h0011, 32'h55AA33AB, 0, 32'h0,        1);
    step("lw10_sb",      OP_LW,  32'h0010, 32'h0,        0, 32'h1234AB78, 0);
    step("lb11",         OP_LB,  32'h0011, 32'h0,        0, 32'hFFFFFFAB, 0);
    step("lbu11",        OP_LBU, 32'h0011, 32'h0,        0, 32'h000000AB, 0);
    step("lb10_pos",     OP_LB,  32'h0010, 32'h0,        0, 32'h00000078, 0);
    step("sh12",         OP_SH,  32'h0013, 32'hFFFF8001, 0, 32'h0,        1);
    step("lw10_sh",      OP_LW,  32'h0010, 32'h0,        0, 32'h8001AB78, 0);
    step("lh12",         OP_LH,  32'h0012, 32'h0,        0, 32'hFFFF8001, 0);
    step("lhu12",        OP_LHU, 32'h0012, 32'h0,        0, 32'h00008001, 0);
    step("lh10_pos",     OP_LH,  32'h0010, 32'h0,        0, 32'hFFFFAB78, 0);
    step("sw_top",       OP_SW,  32'h2FFE, 32'hCAFEF00D, 0, 32'h0,        1);
    step("lw_top",       OP_LW,  32'h2FFC, 32'h0,        0, 32'hCAFEF00D, 0);
    step("lbu_top",      OP_LBU, 32'h2FFF, 32'h0,        0, 32'h000000CA, 0);
    step("sw_oor",       OP_SW,  32'h3000, 32'h11111111, 0, 32'h0,        0);
    step("lw_oor",       OP_LW,  32'h3000, 32'h0,        0, 32'h0,        0);
    step("sw_oor_hi",    OP_SW,  32'h80000010, 32'h22222222, 0, 32'h0,    0);
    step("lw10_keep",    OP_LW,  32'h0010, 32'h0,        0, 32'h8001AB78, 0);
    step("sw20_rst",     OP_SW,  32'h0020, 32'hDEADBEEF, 1, 32'h0,        0);
    step("lw20_rst",     OP_LW,  32'h0020, 32'h0,        0, 32'h0,        0);
    step("sw20",         OP_SW,  32'h0020, 32'hDEADBEEF, 0, 32'h0,        1);
    step("sb23",         OP_SB,  32'h0023, 32'h00000011, 0, 32'h0,        1);
    step("lw20",         OP_LW,  32'h0020, 32'h0,        0, 32'h11ADBEEF, 0);
    step("nop_out",      NOP,    32'h0020, 32'hFFFFFFFF, 0, 32'h0,        0);
    step("reset2",       OP_LW,  32'h0020, 32'h0,        1, 32'h11ADBEEF, 0);
    step("lw20_clr",     OP_LW,  32'h0020, 32'h0,        0, 32'h0,        0);
    step("lw10_clr",     OP_LW,  32'h0010, 32'h0,        0, 32'h0,        0);
    step("lw_top_clr2",  OP_LW,  32'h2FFC, 32'h0,        0, 32'h0,        0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
